// File: rtl/render_frame_scheduler.sv
// Per-frame render pass sequencer: raster coordinate issue, scene snapshot,
// pixel accounting and ping-pong bank swap. Optional RENDER_FRAME_SCHEDULER_STATS_EN adds an overrun counter.
module render_frame_scheduler #(
  parameter int unsigned START_X       = 390,
  parameter int unsigned START_Y       = 390,
  parameter int unsigned END_X         = 634,
  parameter int unsigned END_Y         = 765,
  parameter int unsigned REGION_DIVIDE = 530,
  parameter int unsigned SCENE_W       = 192
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               nf_in,
  input  logic [SCENE_W-1:0] sphere_in,
  output logic [SCENE_W-1:0] sphere_out,
  output logic [10:0]        hcount_out,
  output logic [9:0]         vcount_out,
  output logic               coord_valid,
  input  logic               coord_ready,
  output logic [1:0]         select_objs,
  input  logic               pixel_valid_in,
  output logic               wr_bank,
  output logic               rd_bank,
  output logic               busy,
  output logic               frame_done,
  output logic [15:0]        skipped_frames
);

  localparam int unsigned HW    = 11;
  localparam int unsigned VW    = 10;
  localparam int unsigned TOTAL = (END_X - START_X) * (END_Y - START_Y);
  localparam int unsigned CNT_W = $clog2(TOTAL + 1);

  localparam logic [HW-1:0]    H_FIRST = HW'(START_X);
  localparam logic [HW-1:0]    H_LAST  = HW'(END_X - 1);
  localparam logic [VW-1:0]    V_FIRST = VW'(START_Y);
  localparam logic [VW-1:0]    V_LAST  = VW'(END_Y - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TOTAL);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    DRAIN     = 2'd2,
    WAIT_SWAP = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] pix_cnt;

  logic          hs_c;
  logic          row_end_c;
  logic          last_beat_c;
  logic          start_c;
  logic [VW-1:0] v_inc_c;

  function automatic logic [1:0] region_sel(input logic [VW-1:0] v);
    return (32'(v) < REGION_DIVIDE) ? 2'b11 : 2'b10;
  endfunction

  always_comb begin
    hs_c        = coord_valid && coord_ready;
    row_end_c   = (hcount_out == H_LAST);
    last_beat_c = row_end_c && (vcount_out == V_LAST);
    start_c     = nf_in && ((state == IDLE) || (state == WAIT_SWAP));
    v_inc_c     = vcount_out + VW'(1);
  end

  // Pass sequencer; every output is updated together with the state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      coord_valid <= 1'b0;
      hcount_out  <= H_FIRST;
      vcount_out  <= V_FIRST;
      select_objs <= 2'b11;
      sphere_out  <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b1;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE, WAIT_SWAP: begin
          if (nf_in) begin
            state       <= ISSUE;
            coord_valid <= 1'b1;
            busy        <= 1'b1;
            sphere_out  <= sphere_in;
            hcount_out  <= H_FIRST;
            vcount_out  <= V_FIRST;
            select_objs <= region_sel(V_FIRST);
            // Only a completed pass flips the banks; the first pass after reset does not
            if (state == WAIT_SWAP) begin
              wr_bank    <= ~wr_bank;
              rd_bank    <= wr_bank;
              frame_done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (hs_c) begin
            if (last_beat_c) begin
              coord_valid <= 1'b0;
              state       <= DRAIN;
              hcount_out  <= H_FIRST;
            end else if (row_end_c) begin
              hcount_out  <= H_FIRST;
              vcount_out  <= v_inc_c;
              select_objs <= region_sel(v_inc_c);
            end else begin
              hcount_out <= hcount_out + HW'(1);
            end
          end
        end
        DRAIN: begin
          if (pix_cnt == CNT_MAX) begin
            state <= WAIT_SWAP;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Returned-pixel counter, live only during a pass and saturating at a full frame
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pix_cnt <= '0;
    end else if (start_c) begin
      pix_cnt <= '0;
    end else if (busy && pixel_valid_in && (pix_cnt != CNT_MAX)) begin
      pix_cnt <= pix_cnt + CNT_W'(1);
    end
  end

`ifdef RENDER_FRAME_SCHEDULER_STATS_EN
  // Frames the renderer could not finish in time (new-frame pulse mid-pass)
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      skipped_frames <= '0;
    end else if (nf_in && busy && (skipped_frames != 16'hFFFF)) begin
      skipped_frames <= skipped_frames + 16'd1;
    end
  end
`else
  assign skipped_frames = '0;
`endif

endmodule

// File: tb/tb_render_frame_scheduler.sv
// Scoreboard bench for render_frame_scheduler on a reduced-height window
// (full 244-pixel rows, six lines straddling the region divide).
module tb_render_frame_scheduler;

  localparam int unsigned SX    = 390;
  localparam int unsigned EX    = 634;
  localparam int unsigned SY    = 526;
  localparam int unsigned EY    = 532;
  localparam int unsigned RDIV  = 530;
  localparam int unsigned SW    = 192;
  localparam int unsigned TOTAL = (EX - SX) * (EY - SY);

`ifdef RENDER_FRAME_SCHEDULER_STATS_EN
  localparam logic [15:0] SKIP1 = 16'd1;
  localparam logic [15:0] SKIP2 = 16'd2;
`else
  localparam logic [15:0] SKIP1 = 16'd0;
  localparam logic [15:0] SKIP2 = 16'd0;
`endif

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic [1:0]  sel;
  } beat_t;

  logic          aclk;
  logic          aresetn;
  logic          nf_in;
  logic [SW-1:0] sphere_in;
  logic [SW-1:0] sphere_out;
  logic [10:0]   hcount_out;
  logic [9:0]    vcount_out;
  logic          coord_valid;
  logic          coord_ready;
  logic [1:0]    select_objs;
  logic          pixel_valid_in;
  logic          wr_bank;
  logic          rd_bank;
  logic          busy;
  logic          frame_done;
  logic [15:0]   skipped_frames;

  int    errors = 0;
  int    checks = 0;
  int    beats  = 0;
  int    ready_mode = 0;
  beat_t exp_q[$];
  beat_t prev_beat;
  logic  stall_prev = 1'b0;

  logic [SW-1:0] sph_a, sph_b, sph_c, sph_d, sph_e;

  render_frame_scheduler #(
    .START_X(SX), .START_Y(SY), .END_X(EX), .END_Y(EY),
    .REGION_DIVIDE(RDIV), .SCENE_W(SW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .nf_in(nf_in),
    .sphere_in(sphere_in), .sphere_out(sphere_out),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .coord_valid(coord_valid), .coord_ready(coord_ready),
    .select_objs(select_objs), .pixel_valid_in(pixel_valid_in),
    .wr_bank(wr_bank), .rd_bank(rd_bank), .busy(busy),
    .frame_done(frame_done), .skipped_frames(skipped_frames)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected raster order for one whole pass
  task automatic push_pass();
    beat_t b;
    for (int v = SY; v < EY; v++) begin
      for (int h = SX; h < EX; h++) begin
        b.h   = 11'(h);
        b.v   = 10'(v);
        b.sel = (v < RDIV) ? 2'b11 : 2'b10;
        exp_q.push_back(b);
      end
    end
    beats = 0;
  endtask

  task automatic pulse_nf();
    nf_in = 1'b1;
    tick();
    nf_in = 1'b0;
  endtask

  task automatic wait_pass_end();
    int n;
    n = 0;
    while (coord_valid && n < int'(TOTAL) * 8) begin
      tick();
      n++;
    end
    checks++;
    if (coord_valid) begin
      errors++;
      $display("FAIL pass_end_timeout: coord_valid still %0b after %0d cycles", coord_valid, n);
    end
    chk("beat_count", SW'(beats), SW'(TOTAL));
    chk("queue_left", SW'(exp_q.size()), SW'(0));
  endtask

  // Ready pattern: 0 low, 1 always high, 2 pseudo-random
  initial begin
    coord_ready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      case (ready_mode)
        1:       coord_ready = 1'b1;
        2:       coord_ready = (($urandom % 3) != 0);
        default: coord_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops one expected beat per handshake and checks stall stability
  always @(negedge aclk) begin
    beat_t cur, e;
    cur.h   = hcount_out;
    cur.v   = vcount_out;
    cur.sel = select_objs;
    if (!aresetn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && coord_valid)
        chk("stall_hold", SW'(cur), SW'(prev_beat));
      if (coord_valid && coord_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got h=%0d v=%0d expected no beat", cur.h, cur.v);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("beat%0d", beats), SW'(cur), SW'(e));
        end
        beats++;
      end
      stall_prev = coord_valid && !coord_ready;
      prev_beat  = cur;
    end
  end

  initial begin
    sph_a = {6{32'hA5A5_0001}};
    sph_b = {6{32'h5A5A_0002}};
    sph_c = {6{32'hC3C3_0003}};
    sph_d = {6{32'h3C3C_0004}};
    sph_e = {6{32'h0F0F_0005}};
    aresetn        = 1'b0;
    nf_in          = 1'b0;
    sphere_in      = sph_a;
    pixel_valid_in = 1'b0;
    repeat (3) tick();

    chk("rst_valid", SW'(coord_valid), SW'(0));
    chk("rst_h", SW'(hcount_out), SW'(SX));
    chk("rst_v", SW'(vcount_out), SW'(SY));
    chk("rst_sel", SW'(select_objs), SW'(2'b11));
    chk("rst_sphere", sphere_out, '0);
    chk("rst_wr", SW'(wr_bank), SW'(0));
    chk("rst_rd", SW'(rd_bank), SW'(1));
    chk("rst_busy", SW'(busy), SW'(0));
    chk("rst_done", SW'(frame_done), SW'(0));
    chk("rst_skip", SW'(skipped_frames), SW'(0));
    aresetn = 1'b1;
    tick();

    // Pass 1: always ready, full pixel return
    ready_mode = 1;
    push_pass();
    chk("p1_valid_before", SW'(coord_valid), SW'(0));
    pulse_nf();
    chk("p1_valid_after", SW'(coord_valid), SW'(1));
    chk("p1_sphere", sphere_out, sph_a);
    chk("p1_busy", SW'(busy), SW'(1));
    wait_pass_end();
    chk("p1_drain_busy", SW'(busy), SW'(1));
    pixel_valid_in = 1'b1;
    repeat (TOTAL) tick();
    pixel_valid_in = 1'b0;
    tick();
    chk("p1_wait_busy", SW'(busy), SW'(0));
    chk("p1_wait_wr", SW'(wr_bank), SW'(0));
    chk("p1_wait_done", SW'(frame_done), SW'(0));

    // Swap into pass 2
    sphere_in = sph_b;
    push_pass();
    pulse_nf();
    chk("sw1_done", SW'(frame_done), SW'(1));
    chk("sw1_wr", SW'(wr_bank), SW'(1));
    chk("sw1_rd", SW'(rd_bank), SW'(0));
    chk("sw1_sphere", sphere_out, sph_b);
    chk("sw1_valid", SW'(coord_valid), SW'(1));
    tick();
    chk("sw1_done_pulse", SW'(frame_done), SW'(0));

    // Pass 2: random stalls, scene change and overruns
    ready_mode = 2;
    repeat (50) tick();
    sphere_in = sph_c;
    repeat (5) tick();
    chk("p2_sphere_hold", sphere_out, sph_b);
    pulse_nf();
    chk("p2_ovr_done", SW'(frame_done), SW'(0));
    chk("p2_ovr_wr", SW'(wr_bank), SW'(1));
    chk("p2_ovr_busy", SW'(busy), SW'(1));
    chk("p2_ovr_skip", SW'(skipped_frames), SW'(SKIP1));
    wait_pass_end();
    pixel_valid_in = 1'b1;
    repeat (TOTAL - 1) tick();
    pixel_valid_in = 1'b0;
    tick();
    chk("p2_short_busy", SW'(busy), SW'(1));
    pulse_nf();
    chk("p2_drn_done", SW'(frame_done), SW'(0));
    chk("p2_drn_wr", SW'(wr_bank), SW'(1));
    chk("p2_drn_rd", SW'(rd_bank), SW'(0));
    chk("p2_drn_busy", SW'(busy), SW'(1));
    chk("p2_drn_skip", SW'(skipped_frames), SW'(SKIP2));
    chk("p2_drn_valid", SW'(coord_valid), SW'(0));
    pixel_valid_in = 1'b1;
    tick();
    pixel_valid_in = 1'b0;
    chk("p2_last_px_busy", SW'(busy), SW'(1));
    tick();
    chk("p2_wait_busy", SW'(busy), SW'(0));

    // Pass 3: pixels returned alongside the coordinate stream
    ready_mode = 1;
    sphere_in  = sph_d;
    push_pass();
    pulse_nf();
    chk("sw2_done", SW'(frame_done), SW'(1));
    chk("sw2_wr", SW'(wr_bank), SW'(0));
    chk("sw2_rd", SW'(rd_bank), SW'(1));
    chk("sw2_sphere", sphere_out, sph_d);
    fork
      begin
        pixel_valid_in = 1'b1;
        repeat (TOTAL) tick();
        pixel_valid_in = 1'b0;
      end
      wait_pass_end();
    join
    chk("p3_drain_busy", SW'(busy), SW'(1));
    tick();
    chk("p3_wait_busy", SW'(busy), SW'(0));

    // Pass 4: asynchronous reset mid-issue
    push_pass();
    pulse_nf();
    chk("sw3_wr", SW'(wr_bank), SW'(1));
    repeat (100) tick();
    aresetn = 1'b0;
    #1;
    chk("arst_valid", SW'(coord_valid), SW'(0));
    chk("arst_wr", SW'(wr_bank), SW'(0));
    chk("arst_rd", SW'(rd_bank), SW'(1));
    chk("arst_busy", SW'(busy), SW'(0));
    chk("arst_h", SW'(hcount_out), SW'(SX));
    chk("arst_sphere", sphere_out, '0);
    tick();
    aresetn = 1'b1;
    exp_q.delete();
    repeat (3) tick();
    chk("arst_skip", SW'(skipped_frames), SW'(0));

    // Pass 5: clean restart from IDLE
    sphere_in = sph_e;
    push_pass();
    pulse_nf();
    chk("p5_valid", SW'(coord_valid), SW'(1));
    chk("p5_done", SW'(frame_done), SW'(0));
    chk("p5_wr", SW'(wr_bank), SW'(0));
    chk("p5_sphere", sphere_out, sph_e);
    wait_pass_end();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
